// File: rtl/sync_pdp_ram.sv
// Double-buffered frame RAM: the loader writes the back bank while scan-out reads
// the top-half and bottom-half pixel of the front bank in a single cycle.
module sync_pdp_ram #(
    parameter int BITS_PER_PIXEL = 32
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      buffer_toggle,
    input  logic [10:0]               write_addr,
    input  logic [BITS_PER_PIXEL-1:0] write_data,
    input  logic                      write_en,
    input  logic [9:0]                read_addr,
    output logic [BITS_PER_PIXEL-1:0] read_data_top,
    output logic [BITS_PER_PIXEL-1:0] read_data_bottom,
    input  logic                      read_en
);

    logic [BITS_PER_PIXEL-1:0] bank0_top_q [1024];
    logic [BITS_PER_PIXEL-1:0] bank0_bot_q [1024];
    logic [BITS_PER_PIXEL-1:0] bank1_top_q [1024];
    logic [BITS_PER_PIXEL-1:0] bank1_bot_q [1024];

    logic [BITS_PER_PIXEL-1:0] rd_top_q;
    logic [BITS_PER_PIXEL-1:0] rd_bot_q;

    // Storage is left untouched by reset; only the write strobe is suppressed while it is held.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_top_q <= '0;
            rd_bot_q <= '0;
        end else begin
            if (write_en) begin
                case ({buffer_toggle, write_addr[10]})
                    2'b00:   bank0_top_q[write_addr[9:0]] <= write_data;
                    2'b01:   bank0_bot_q[write_addr[9:0]] <= write_data;
                    2'b10:   bank1_top_q[write_addr[9:0]] <= write_data;
                    default: bank1_bot_q[write_addr[9:0]] <= write_data;
                endcase
            end
            // The read side always targets the bank opposite the writer, so no collision exists.
            if (read_en) begin
                if (buffer_toggle) begin
                    rd_top_q <= bank0_top_q[read_addr];
                    rd_bot_q <= bank0_bot_q[read_addr];
                end else begin
                    rd_top_q <= bank1_top_q[read_addr];
                    rd_bot_q <= bank1_bot_q[read_addr];
                end
            end
        end
    end

    assign read_data_top    = rd_top_q;
    assign read_data_bottom = rd_bot_q;

endmodule

// File: tb/tb_sync_pdp_ram.sv
// Self-checking bench for sync_pdp_ram: directed fills, a vector table for bank
// switching and boundaries, a mid-run reset sequence and a randomized phase.
module tb_sync_pdp_ram;
    localparam int W = 32;

    logic          clk = 1'b0;
    logic          reset_n = 1'b1;
    logic          buffer_toggle = 1'b0;
    logic [10:0]   write_addr = '0;
    logic [W-1:0]  write_data = '0;
    logic          write_en = 1'b0;
    logic [9:0]    read_addr = '0;
    logic [W-1:0]  read_data_top;
    logic [W-1:0]  read_data_bottom;
    logic          read_en = 1'b0;

    sync_pdp_ram #(.BITS_PER_PIXEL(W)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .buffer_toggle    (buffer_toggle),
        .write_addr       (write_addr),
        .write_data       (write_data),
        .write_en         (write_en),
        .read_addr        (read_addr),
        .read_data_top    (read_data_top),
        .read_data_bottom (read_data_bottom),
        .read_en          (read_en)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Reference: two flat 2048-word frames plus the expected output registers.
    logic [W-1:0] model [2][2048];
    logic [W-1:0] exp_top = '0;
    logic [W-1:0] exp_bot = '0;

    typedef struct {
        logic         tog;
        logic         we;
        logic [10:0]  waddr;
        logic [31:0]  wdata;
        logic         re;
        logic [9:0]   raddr;
        logic [31:0]  etop;
        logic [31:0]  ebot;
    } vec_t;

    vec_t vecs [13];

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic drive(input logic tog, input logic we, input logic [10:0] waddr,
                         input logic [W-1:0] wdata, input logic re, input logic [9:0] raddr);
        buffer_toggle = tog;
        write_en      = we;
        write_addr    = waddr;
        write_data    = wdata;
        read_en       = re;
        read_addr     = raddr;
    endtask

    task automatic tick();
        int wb, rb;
        @(posedge clk);
        wb = buffer_toggle ? 1 : 0;
        rb = 1 - wb;
        if (reset_n) begin
            if (read_en) begin
                exp_top = model[rb][int'({1'b0, read_addr})];
                exp_bot = model[rb][int'({1'b1, read_addr})];
            end
            if (write_en) model[wb][int'(write_addr)] = write_data;
        end
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{1'b1, 1'b1, 11'd5,    32'hDEADBEEF, 1'b1, 10'd5,    32'h00000005, 32'h00000405};
        vecs[1]  = '{1'b1, 1'b0, 11'd0,    32'h0,        1'b0, 10'd9,    32'h00000005, 32'h00000405};
        vecs[2]  = '{1'b1, 1'b0, 11'd6,    32'h12345678, 1'b0, 10'd100,  32'h00000005, 32'h00000405};
        vecs[3]  = '{1'b0, 1'b0, 11'd0,    32'h0,        1'b1, 10'd5,    32'hDEADBEEF, 32'h10000405};
        vecs[4]  = '{1'b0, 1'b0, 11'd0,    32'h0,        1'b1, 10'd6,    32'h10000006, 32'h10000406};
        vecs[5]  = '{1'b0, 1'b1, 11'd1023, 32'hAAAA0001, 1'b1, 10'd1023, 32'h100003FF, 32'h100007FF};
        vecs[6]  = '{1'b0, 1'b1, 11'd1024, 32'hBBBB0002, 1'b1, 10'd0,    32'h10000000, 32'h10000400};
        vecs[7]  = '{1'b1, 1'b0, 11'd0,    32'h0,        1'b1, 10'd1023, 32'hAAAA0001, 32'h000007FF};
        vecs[8]  = '{1'b1, 1'b0, 11'd0,    32'h0,        1'b1, 10'd0,    32'h00000000, 32'hBBBB0002};
        vecs[9]  = '{1'b0, 1'b1, 11'd10,   32'hC0FFEE00, 1'b1, 10'd10,   32'h1000000A, 32'h1000040A};
        vecs[10] = '{1'b1, 1'b0, 11'd0,    32'h0,        1'b1, 10'd10,   32'hC0FFEE00, 32'h0000040A};
        vecs[11] = '{1'b1, 1'b1, 11'd20,   32'h00005555, 1'b1, 10'd20,   32'h00000014, 32'h00000414};
        vecs[12] = '{1'b0, 1'b0, 11'd0,    32'h0,        1'b1, 10'd20,   32'h00005555, 32'h10000414};

        // Power-on reset is asynchronous: outputs clear without a clock edge.
        #1 reset_n = 1'b0;
        #1;
        check("por_top", read_data_top, '0);
        check("por_bot", read_data_bottom, '0);
        repeat (2) tick();
        reset_n = 1'b1;
        drive(1'b0, 1'b0, '0, '0, 1'b0, '0);
        tick();
        check("release_hold_top", read_data_top, '0);
        check("release_hold_bot", read_data_bottom, '0);

        for (int a = 0; a < 2048; a++) begin
            drive(1'b0, 1'b1, 11'(a), W'(a), 1'b0, '0);
            tick();
        end

        for (int k = 0; k < 1024; k++) begin
            drive(1'b1, 1'b0, '0, '0, 1'b1, 10'(k));
            tick();
            check("fill_read_top", read_data_top, W'(k));
            check("fill_read_bot", read_data_bottom, W'(k + 1024));
        end

        // Load the other frame while scan-out keeps reading the first one.
        for (int a = 0; a < 2048; a++) begin
            drive(1'b1, 1'b1, 11'(a), 32'h1000_0000 | W'(a), 1'b1, 10'(a % 1024));
            tick();
            check("overlap_top", read_data_top, W'(a % 1024));
            check("overlap_bot", read_data_bottom, W'((a % 1024) + 1024));
        end

        for (int i = 0; i < 13; i++) begin
            drive(vecs[i].tog, vecs[i].we, vecs[i].waddr, vecs[i].wdata, vecs[i].re, vecs[i].raddr);
            tick();
            check($sformatf("vec%0d_top", i), read_data_top, vecs[i].etop);
            check($sformatf("vec%0d_bot", i), read_data_bottom, vecs[i].ebot);
        end

        // Mid-run reset away from any clock edge; a write attempted during it must be dropped.
        @(negedge clk);
        reset_n = 1'b0;
        exp_top = '0;
        exp_bot = '0;
        #1;
        check("midrst_async_top", read_data_top, '0);
        check("midrst_async_bot", read_data_bottom, '0);
        drive(1'b0, 1'b1, 11'd5, 32'h00000BAD, 1'b1, 10'd5);
        tick();
        check("midrst_edge_top", read_data_top, '0);
        reset_n = 1'b1;
        drive(1'b1, 1'b0, '0, '0, 1'b0, 10'd5);
        tick();
        check("midrst_release_top", read_data_top, '0);
        check("midrst_release_bot", read_data_bottom, '0);
        drive(1'b1, 1'b0, '0, '0, 1'b1, 10'd5);
        tick();
        check("midrst_read_top", read_data_top, 32'h00000005);
        check("midrst_read_bot", read_data_bottom, 32'h00000405);

        for (int i = 0; i < 2000; i++) begin
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 11'($urandom_range(0, 2047)),
                  W'($urandom), 1'($urandom_range(0, 3) != 0), 10'($urandom_range(0, 1023)));
            tick();
            check("rand_top", read_data_top, exp_top);
            check("rand_bot", read_data_bottom, exp_bot);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
